// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared types and constants for the immediate encoder
package imm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } imm_enc_state_t;

    localparam int IMM_ROT_W = 4;
    localparam int IMM_VAL_W = 8;
    localparam int IMM_ENC_W = 12;
    localparam logic [IMM_ROT_W-1:0] IMM_ROT_MAX = 4'd15;

endpackage

// File: rtl/imm_rot_check.sv
// rtl/imm_rot_check.sv - tests one rotation: does ROL(val, 2*rot) fit in 8 bits
module imm_rot_check
    import imm_pkg::*;
(
    input  logic [31:0]          val,
    input  logic [IMM_ROT_W-1:0] rot,
    output logic                 hit,
    output logic [IMM_VAL_W-1:0] imm8
);

    logic [5:0]  amt;
    logic [31:0] t;

    // Rotating left by 2*rot undoes the ROR applied when the immediate is expanded.
    always_comb begin
        amt  = {1'b0, rot, 1'b0};
        // amt == 0 makes the right shift 32 wide, which yields 0 and leaves t == val
        t    = (val << amt) | (val >> (6'd32 - amt));
        hit  = (t[31:IMM_VAL_W] == '0);
        imm8 = t[IMM_VAL_W-1:0];
    end

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - iterative ARM rotated-immediate encoder; optional IMM_ENC_SEXT_EN adds 12-bit signed fit outputs
module imm_encoder
    import imm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    output logic              busy,
    output logic              done,
    output logic              valid,
`ifdef IMM_ENC_SEXT_EN
    output logic [IMM_W-1:0]  imm12,
    output logic              sext_ok,
    output logic [IMM_W-1:0]  sext_imm
`else
    output logic [IMM_W-1:0]  imm12
`endif
);

    imm_enc_state_t        state;
    logic [DATA_W-1:0]     val_q;
    logic [IMM_ROT_W-1:0]  rot_q;
    logic                  hit;
    logic [IMM_VAL_W-1:0]  imm8;
    logic                  last_rot;

    imm_rot_check u_rot_check (
        .val  (val_q),
        .rot  (rot_q),
        .hit  (hit),
        .imm8 (imm8)
    );

    assign last_rot = (rot_q == IMM_ROT_MAX);

`ifdef IMM_ENC_SEXT_EN
    logic sext_fit;

    // The constant fits a signed 12-bit field when its top 21 bits are all copies of the sign.
    always_comb begin
        sext_fit = (&val_q[31:11]) | ~(|val_q[31:11]);
    end
`endif

    // Search FSM: one rotation per cycle, results registered on the edge that raises done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            val_q <= '0;
            rot_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            valid <= 1'b0;
            imm12 <= '0;
`ifdef IMM_ENC_SEXT_EN
            sext_ok  <= 1'b0;
            sext_imm <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // DONE accepts a new request directly so back-to-back starts lose no cycle
                    if (start) begin
                        val_q <= value;
                        rot_q <= '0;
                        busy  <= 1'b1;
                        state <= SEARCH;
                    end else begin
                        state <= IDLE;
                    end
                end
                SEARCH: begin
                    // First hit wins, so the reported rotation is the smallest one.
                    if (hit || last_rot) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        valid <= hit;
                        imm12 <= hit ? {rot_q, imm8} : '0;
`ifdef IMM_ENC_SEXT_EN
                        sext_ok  <= sext_fit;
                        sext_imm <= sext_fit ? val_q[IMM_W-1:0] : '0;
`endif
                        state <= DONE;
                    end else begin
                        rot_q <= rot_q + 4'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
